// File: rtl/pong_pkg.sv
// Shared types and playfield geometry for the pong ball logic.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } ball_state_t;

  localparam logic DIR_POS = 1'b0;  // right / down
  localparam logic DIR_NEG = 1'b1;  // left / up

  localparam int H_MAX    = 1023;
  localparam int V_MAX    = 767;
  localparam int BALL_R   = 10;
  localparam int PAD_L_X  = 32;
  localparam int PAD_R_X  = 991;
  localparam int PAD_HALF = 48;

endpackage

// File: rtl/ball_tick_gen.sv
// Loadable down-counter producing a one-cycle motion tick every TICK_DIV cycles of run.
module ball_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic pclk,
  input  logic reset,
  input  logic run,
  input  logic reload,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = run && !reload && (cnt_q == '0);

  always_ff @(posedge pclk) begin
    if (reset || reload) begin
      cnt_q <= LOAD;
    end else if (run) begin
      cnt_q <= (cnt_q == '0) ? LOAD : cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_ctl.sv
// Pong ball controller: serve/play/point/over sequencing, tick-driven motion, bounces and scoring.
// Optional BALL_SPEEDUP_EN raises the step by one every fourth paddle hit (max 4).
module ball_motion_ctl #(
  parameter int H_MAX      = pong_pkg::H_MAX,
  parameter int V_MAX      = pong_pkg::V_MAX,
  parameter int BALL_R     = pong_pkg::BALL_R,
  parameter int PAD_L_X    = pong_pkg::PAD_L_X,
  parameter int PAD_R_X    = pong_pkg::PAD_R_X,
  parameter int PAD_HALF   = pong_pkg::PAD_HALF,
  parameter int TICK_DIV   = 1_000_000,
  parameter int POINT_HOLD = 64,
  parameter int SCORE_MAX  = 9
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        serve,
  input  logic [11:0] pad_l_y,
  input  logic [11:0] pad_r_y,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        in_play,
  output logic        point_l,
  output logic        point_r,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  import pong_pkg::*;

  localparam logic [12:0] HM  = 13'(H_MAX);
  localparam logic [12:0] VM  = 13'(V_MAX);
  localparam logic [12:0] R13 = 13'(BALL_R);
  localparam logic [12:0] PL  = 13'(PAD_L_X);
  localparam logic [12:0] PR  = 13'(PAD_R_X);
  localparam logic [12:0] PH  = 13'(PAD_HALF);
  localparam logic [11:0] X_CTR = 12'((H_MAX + 1) / 2);
  localparam logic [11:0] Y_CTR = 12'((V_MAX + 1) / 2);
  localparam logic [3:0]  S_MAX = 4'(SCORE_MAX);
  localparam int HW = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(POINT_HOLD - 1);

  ball_state_t   state_q, state_d;
  logic [11:0]   x_q, x_d, y_q, y_d;
  logic          dx_q, dx_d, dy_q, dy_d;
  logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;
  logic          point_l_q, point_l_d, point_r_q, point_r_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    step;
  logic          tick;
  logic          hold_done;

  ball_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .pclk   (pclk),
    .reset  (reset),
    .run    ((state_q == ST_PLAY) || (state_q == ST_POINT)),
    .reload ((state_q == ST_IDLE) || (state_q == ST_OVER)),
    .tick   (tick)
  );

  // All geometry compares are 13 bits wide so sums near the field edge cannot wrap.
  logic [12:0] x13, y13, s13, dist_l, dist_r;
  logic        hit_r, hit_l;

  assign x13    = {1'b0, x_q};
  assign y13    = {1'b0, y_q};
  assign s13    = {10'd0, step};
  assign dist_r = (y_q >= pad_r_y) ? y13 - {1'b0, pad_r_y} : {1'b0, pad_r_y} - y13;
  assign dist_l = (y_q >= pad_l_y) ? y13 - {1'b0, pad_l_y} : {1'b0, pad_l_y} - y13;
  assign hit_r  = (x13 + R13 + s13 >= PR) && (x13 + R13 <= PR) && (dist_r <= PH + R13);
  assign hit_l  = (x13 <= PL + R13 + s13) && (x13 >= PL + R13) && (dist_l <= PH + R13);
  assign hold_done = (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    point_l_d = 1'b0;
    point_r_d = 1'b0;
    hold_d    = hold_q;
    case (state_q)
      ST_IDLE: begin
        x_d    = X_CTR;
        y_d    = Y_CTR;
        hold_d = '0;
        if (serve) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (tick) begin
          if (dy_q == DIR_POS) begin
            if (y13 + R13 + s13 >= VM) begin
              y_d  = 12'(VM - R13);
              dy_d = DIR_NEG;
            end else begin
              y_d = y_q + {9'd0, step};
            end
          end else begin
            if (y13 < R13 + s13) begin
              y_d  = 12'(R13);
              dy_d = DIR_POS;
            end else begin
              y_d = y_q - {9'd0, step};
            end
          end
          // On a miss dx is aimed at the scorer now; the ball stays frozen until recentred.
          if (dx_q == DIR_POS) begin
            if (hit_r) begin
              x_d  = 12'(PR - R13);
              dx_d = DIR_NEG;
            end else if (x13 + R13 + s13 >= HM) begin
              x_d       = 12'(HM - R13);
              dx_d      = DIR_NEG;
              point_l_d = 1'b1;
              score_l_d = (score_l_q == S_MAX) ? score_l_q : score_l_q + 4'd1;
              state_d   = ST_POINT;
            end else begin
              x_d = x_q + {9'd0, step};
            end
          end else begin
            if (hit_l) begin
              x_d  = 12'(PL + R13);
              dx_d = DIR_POS;
            end else if (x13 <= R13 + s13) begin
              x_d       = 12'(R13);
              dx_d      = DIR_POS;
              point_r_d = 1'b1;
              score_r_d = (score_r_q == S_MAX) ? score_r_q : score_r_q + 4'd1;
              state_d   = ST_POINT;
            end else begin
              x_d = x_q - {9'd0, step};
            end
          end
        end
      end
      ST_POINT: begin
        if (tick) begin
          if (hold_done) begin
            x_d     = X_CTR;
            y_d     = Y_CTR;
            hold_d  = '0;
            state_d = ((score_l_q == S_MAX) || (score_r_q == S_MAX)) ? ST_OVER : ST_IDLE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= X_CTR;
      y_q       <= Y_CTR;
      dx_q      <= DIR_POS;
      dy_q      <= DIR_POS;
      score_l_q <= '0;
      score_r_q <= '0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
      hold_q    <= hold_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [2:0] hit_cnt_q;
  logic [2:0] step_q;
  logic       paddle_hit;

  assign paddle_hit = (state_q == ST_PLAY) && tick &&
                      (((dx_q == DIR_POS) && hit_r) || ((dx_q == DIR_NEG) && hit_l));

  always_ff @(posedge pclk) begin
    if (reset) begin
      hit_cnt_q <= '0;
      step_q    <= 3'd1;
    end else if ((state_q == ST_POINT) && tick && hold_done) begin
      hit_cnt_q <= '0;
      step_q    <= 3'd1;
    end else if (paddle_hit) begin
      hit_cnt_q <= hit_cnt_q + 3'd1;
      if ((hit_cnt_q[1:0] == 2'b11) && (step_q != 3'd4)) step_q <= step_q + 3'd1;
    end
  end

  assign step = step_q;
`else
  assign step = 3'd1;
`endif

  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign in_play   = (state_q == ST_PLAY);
  assign game_over = (state_q == ST_OVER);
  assign point_l   = point_l_q;
  assign point_r   = point_r_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;

endmodule

// File: tb/tb_ball_motion_ctl.sv
// Directed bench for ball_motion_ctl with TICK_DIV=4, POINT_HOLD=2.
module tb_ball_motion_ctl;

  localparam int TICK_DIV   = 4;
  localparam int POINT_HOLD = 2;
`ifdef BALL_SPEEDUP_EN
  localparam int EXP_STEP = 2;
`else
  localparam int EXP_STEP = 1;
`endif

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        serve = 1'b0;
  logic [11:0] pad_l_y = 12'd384;
  logic [11:0] pad_r_y = 12'd384;
  logic [11:0] x_pos, y_pos;
  logic        in_play, point_l, point_r, game_over;
  logic [3:0]  score_l, score_r;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  int wait_cnt, prev_x, delta, sgn, last_sgn, revs, n_ticks;
  logic timed_out;

  ball_motion_ctl #(.TICK_DIV(TICK_DIV), .POINT_HOLD(POINT_HOLD)) dut (
    .pclk      (pclk),
    .reset     (reset),
    .serve     (serve),
    .pad_l_y   (pad_l_y),
    .pad_r_y   (pad_r_y),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .in_play   (in_play),
    .point_l   (point_l),
    .point_r   (point_r),
    .score_l   (score_l),
    .score_r   (score_r),
    .game_over (game_over)
  );

  // clock / watchdog
  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver tasks: all start and end on a falling edge
  task automatic do_reset();
    reset = 1'b1;
    serve = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    reset = 1'b0;
  endtask

  task automatic serve_ball();
    serve = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    serve = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n * TICK_DIV) @(posedge pclk);
    @(negedge pclk);
  endtask

  initial begin
    @(negedge pclk);
    do_reset();

    // reset state
    check("rst_x", x_pos, 512);
    check("rst_y", y_pos, 384);
    check("rst_in_play", in_play, 0);
    check("rst_game_over", game_over, 0);
    check("rst_score_l", score_l, 0);
    check("rst_score_r", score_r, 0);
    check("rst_points", {point_l, point_r}, 0);

    // serve and first-tick latency
    serve_ball();
    check("serve_in_play", in_play, 1);
    repeat (TICK_DIV - 1) @(posedge pclk);
    @(negedge pclk);
    check("before_first_tick_x", x_pos, 512);
    @(posedge pclk);
    @(negedge pclk);
    check("first_tick_x", x_pos, 513);
    check("first_tick_y", y_pos, 385);

    // bottom wall bounce: y reaches 756 at tick 372
    run_ticks(371);
    check("pre_bounce_y", y_pos, 756);
    check("pre_bounce_x", x_pos, 884);
    run_ticks(1);
    check("bounce_y", y_pos, 757);
    run_ticks(1);
    check("after_bounce_y", y_pos, 756);
    check("after_bounce_x", x_pos, 886);

    // right paddle hit at tick 468 (x=980, y=662)
    pad_r_y = 12'd662;
    run_ticks(94);
    check("pre_hit_x", x_pos, 980);
    check("pre_hit_y", y_pos, 662);
    run_ticks(1);
    check("hit_x", x_pos, 981);
    check("hit_y", y_pos, 661);
    run_ticks(1);
    check("after_hit_x", x_pos, 980);

    // right miss: paddle 100 rows away
    do_reset();
    pad_r_y = 12'd762;
    serve_ball();
    run_ticks(500);
    check("pre_miss_x", x_pos, 1012);
    check("pre_miss_y", y_pos, 630);
    check("pre_miss_point_l", point_l, 0);
    run_ticks(1);
    check("miss_x", x_pos, 1013);
    check("miss_y", y_pos, 629);
    check("miss_point_l", point_l, 1);
    check("miss_score_l", score_l, 1);
    check("miss_in_play", in_play, 0);
    @(posedge pclk);
    @(negedge pclk);
    check("point_l_one_cycle", point_l, 0);
    repeat (TICK_DIV - 1) @(posedge pclk);
    @(negedge pclk);
    check("hold_frozen_x", x_pos, 1013);
    repeat (TICK_DIV) @(posedge pclk);
    @(negedge pclk);
    check("recentre_x", x_pos, 512);
    check("recentre_y", y_pos, 384);
    check("recentre_game_over", game_over, 0);

    // serve after left scored: dx toward left, dy kept (up); serve held as a level
    pad_l_y = 12'd4000;
    serve = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    run_ticks(1);
    check("serve_left_x", x_pos, 511);
    check("serve_left_y", y_pos, 383);

    // right player scores to SCORE_MAX: right paddle tracks the ball, left is absent
    for (int p = 1; p <= 9; p++) exp_q.push_back(4'(p));
    timed_out = 1'b0;
    while (exp_q.size() != 0 && !timed_out) begin
      wait_cnt = 0;
      while (point_r !== 1'b1 && wait_cnt < 8000) begin
        @(negedge pclk);
        pad_r_y = y_pos;
        wait_cnt++;
      end
      if (point_r !== 1'b1) begin
        timed_out = 1'b1;
        check("rally_budget", point_r, 1);
      end else begin
        check("score_r", score_r, exp_q.pop_front());
        @(negedge pclk);
      end
    end
    repeat (2 * TICK_DIV) @(posedge pclk);
    @(negedge pclk);
    check("over_game_over", game_over, 1);
    check("over_score_l", score_l, 1);
    check("over_score_r", score_r, 9);
    repeat (20) @(posedge pclk);
    @(negedge pclk);
    check("over_serve_ignored", game_over, 1);
    check("over_in_play", in_play, 0);
    check("over_x", x_pos, 512);
    serve = 1'b0;

    // reset leaves OVER; reset mid-PLAY restores everything in one edge
    do_reset();
    check("over_reset_game_over", game_over, 0);
    serve_ball();
    run_ticks(3);
    check("midplay_x", x_pos, 515);
    reset = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    check("midrst_x", x_pos, 512);
    check("midrst_y", y_pos, 384);
    check("midrst_in_play", in_play, 0);
    check("midrst_scores", {score_l, score_r}, 0);
    serve_ball();
    repeat (TICK_DIV - 1) @(posedge pclk);
    @(negedge pclk);
    check("midrst_latency_x", x_pos, 512);
    @(posedge pclk);
    @(negedge pclk);
    check("midrst_first_x", x_pos, 513);
    check("midrst_first_y", y_pos, 385);

    // speedup: both paddles track, so every approach is a hit
    do_reset();
    pad_l_y = 12'd384;
    pad_r_y = 12'd384;
    serve_ball();
    prev_x = 512;
    last_sgn = 1;
    revs = 0;
    n_ticks = 0;
    while (revs < 4 && n_ticks < 5000) begin
      pad_l_y = y_pos;
      pad_r_y = y_pos;
      run_ticks(1);
      n_ticks++;
      delta = int'(x_pos) - prev_x;
      prev_x = int'(x_pos);
      sgn = (delta < 0) ? -1 : 1;
      if (sgn != last_sgn) begin
        revs++;
        last_sgn = sgn;
        if (revs == 3) check("step_before_4th_hit", (delta < 0) ? -delta : delta, 1);
        if (revs == 4) check("step_after_4th_hit", delta, EXP_STEP);
      end
    end
    check("hit_budget", revs, 4);
    pad_l_y = y_pos;
    pad_r_y = y_pos;
    run_ticks(1);
    check("step_next_tick", int'(x_pos) - prev_x, EXP_STEP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
